// File: rtl/id_stage_pkg.sv
// Shared RV32I decode types and encodings used by the ID stage and its register file.
package id_stage_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } opcode_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        RD_ALU = 2'b00,
        RD_MEM = 2'b01,
        RD_PC4 = 2'b10
    } rd_src_t;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_EX     = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_RF_ALT = 2'b11
    } fwd_sel_t;

    localparam logic [3:0] MEM_NONE = 4'b0000;

    // {store, load_unsigned, size}; a byte load also encodes as 0, so EX tells loads apart by rd_src.
    function automatic logic [3:0] mem_op_enc(input logic store, input logic [2:0] f3);
        return {store, f3[2] & ~store, f3[1:0]};
    endfunction

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        alu_op_t           alu_op;
        logic              alu_src;
        logic [4:0]        rd_addr;
        logic              rd_wr_en;
        rd_src_t           rd_src;
        logic [3:0]        mem_op;
        logic              illegal;
    } id_ex_t;

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port, sync reset.
// Optional RF_WB_BYPASS_EN makes a same-cycle write visible on the read ports (write-first).
module id_stage_reg_file
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic wr_live;
    assign wr_live  = wr_en && (wr_addr != 5'd0);
    assign rs1_data = (wr_live && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
    assign rs2_data = (wr_live && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
`else
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];
`endif

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decoder, immediate generation, operand forwarding, branch resolution
// and the ID/EX pipeline register. Optional macro RF_WB_BYPASS_EN enables register-file write-through.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int              XLEN     = DATA_W,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [31:0]     id_instr_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [1:0]      forward_reg1_i,
    input  logic [1:0]      forward_reg2_i,
    input  logic [XLEN-1:0] ex_fwd_data_i,
    input  logic [XLEN-1:0] mem_fwd_data_i,
    input  logic            wb_rd_wr_en_i,
    input  logic [4:0]      wb_rd_addr_i,
    input  logic [XLEN-1:0] wb_rd_data_i,
    output logic            branch_en_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_data_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [3:0]      ex_alu_op_o,
    output logic            ex_alu_src_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            ex_rd_wr_en_o,
    output logic [1:0]      ex_rd_src_o,
    output logic [3:0]      ex_mem_op_o,
    output logic            ex_illegal_o
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [XLEN-1:0] jalr_sum;
    logic            writes_rd, is_branch, is_jal, is_jalr, cond;
    id_ex_t          dec, ex_q;

    assign opcode     = id_instr_i[6:0];
    assign f3         = id_instr_i[14:12];
    assign rd         = id_instr_i[11:7];
    assign rs1_addr_o = id_instr_i[19:15];
    assign rs2_addr_o = id_instr_i[24:20];

    id_stage_reg_file u_reg_file (
        .clk      (clk_i),
        .rst      (rst_i),
        .rs1_addr (rs1_addr_o),
        .rs2_addr (rs2_addr_o),
        .rs1_data (rf_rs1),
        .rs2_data (rf_rs2),
        .wr_en    (wb_rd_wr_en_i),
        .wr_addr  (wb_rd_addr_i),
        .wr_data  (wb_rd_data_i)
    );

    // x0 always reads as zero, even when a forwarding path is selected.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [4:0] addr,
                                                input logic [XLEN-1:0] rf, input logic [XLEN-1:0] ex,
                                                input logic [XLEN-1:0] mem);
        logic [XLEN-1:0] r;
        case (fwd_sel_t'(sel))
            FWD_EX:  r = ex;
            FWD_MEM: r = mem;
            default: r = rf;
        endcase
        if (addr == 5'd0) r = '0;
        return r;
    endfunction

    assign rs1_val = fwd_mux(forward_reg1_i, rs1_addr_o, rf_rs1, ex_fwd_data_i, mem_fwd_data_i);
    assign rs2_val = fwd_mux(forward_reg2_i, rs2_addr_o, rf_rs2, ex_fwd_data_i, mem_fwd_data_i);

    assign imm_i = {{20{id_instr_i[31]}}, id_instr_i[31:20]};
    assign imm_s = {{20{id_instr_i[31]}}, id_instr_i[31:25], id_instr_i[11:7]};
    assign imm_b = {{19{id_instr_i[31]}}, id_instr_i[31], id_instr_i[7], id_instr_i[30:25],
                    id_instr_i[11:8], 1'b0};
    assign imm_u = {id_instr_i[31:12], 12'b0};
    assign imm_j = {{11{id_instr_i[31]}}, id_instr_i[31], id_instr_i[19:12], id_instr_i[20],
                    id_instr_i[30:21], 1'b0};

    function automatic alu_op_t alu_decode(input logic [2:0] fn3, input logic alt, input logic is_imm);
        alu_op_t op;
        case (fn3)
            3'b000:  op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = id_pc_i;
        dec.rs1_data = rs1_val;
        dec.rs2_data = rs2_val;
        dec.alu_op   = ALU_ADD;
        dec.rd_src   = RD_ALU;
        dec.mem_op   = MEM_NONE;
        imm          = '0;
        writes_rd    = 1'b0;
        is_branch    = 1'b0;
        is_jal       = 1'b0;
        is_jalr      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm = imm_u; dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                imm = imm_u; dec.alu_op = ALU_AUIPC; dec.alu_src = 1'b1; writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm = imm_j; dec.rd_src = RD_PC4; writes_rd = 1'b1; is_jal = 1'b1;
            end
            OPC_JALR: begin
                imm = imm_i; dec.alu_src = 1'b1; dec.rd_src = RD_PC4; writes_rd = 1'b1; is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                imm = imm_b; dec.alu_op = ALU_SUB; is_branch = 1'b1;
            end
            OPC_LOAD: begin
                imm = imm_i; dec.alu_src = 1'b1; dec.rd_src = RD_MEM; writes_rd = 1'b1;
                dec.mem_op = mem_op_enc(1'b0, f3);
            end
            OPC_STORE: begin
                imm = imm_s; dec.alu_src = 1'b1; dec.mem_op = mem_op_enc(1'b1, f3);
            end
            OPC_OP_IMM: begin
                imm = imm_i; dec.alu_src = 1'b1; writes_rd = 1'b1;
                dec.alu_op = alu_decode(f3, id_instr_i[30], 1'b1);
            end
            OPC_OP: begin
                writes_rd = 1'b1; dec.alu_op = alu_decode(f3, id_instr_i[30], 1'b0);
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // FENCE/ECALL/EBREAK travel down the pipe as side-effect-free NOPs.
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm      = imm;
        dec.rd_wr_en = writes_rd & (rd != 5'd0);
        dec.rd_addr  = dec.rd_wr_en ? rd : 5'd0;
    end

    always_comb begin
        case (f3)
            F3_BEQ:  cond = (rs1_val == rs2_val);
            F3_BNE:  cond = (rs1_val != rs2_val);
            F3_BLT:  cond = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  cond = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: cond = (rs1_val <  rs2_val);
            F3_BGEU: cond = (rs1_val >= rs2_val);
            default: cond = 1'b0;
        endcase
    end

    assign jalr_sum        = rs1_val + imm;
    assign branch_target_o = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (id_pc_i + imm);
    assign branch_en_o     = id_valid_i & ~stall_i & ~flush_i &
                             (is_jal | is_jalr | (is_branch & cond));

    function automatic id_ex_t bubble();
        id_ex_t b;
        b    = '0;
        b.pc = RESET_PC;
        return b;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= bubble();
        end else if (flush_i || stall_i || !id_valid_i) begin
            ex_q <= bubble();
        end else begin
            ex_q <= dec;
        end
    end

    assign ex_valid_o    = ex_q.valid;
    assign ex_pc_o       = ex_q.pc;
    assign ex_rs1_data_o = ex_q.rs1_data;
    assign ex_rs2_data_o = ex_q.rs2_data;
    assign ex_imm_o      = ex_q.imm;
    assign ex_alu_op_o   = ex_q.alu_op;
    assign ex_alu_src_o  = ex_q.alu_src;
    assign ex_rd_addr_o  = ex_q.rd_addr;
    assign ex_rd_wr_en_o = ex_q.rd_wr_en;
    assign ex_rd_src_o   = ex_q.rd_src;
    assign ex_mem_op_o   = ex_q.mem_op;
    assign ex_illegal_o  = ex_q.illegal;

endmodule
